// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in / serial-out serializer.
// The PARITY state exists only when PISO_SERIALIZER_PARITY_EN is defined.
package piso_pkg;

    localparam int PISO_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1
`ifdef PISO_SERIALIZER_PARITY_EN
        ,
        PARITY = 2'd2
`endif
    } piso_state_e;

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out serializer, LSB first, with shift_en stall control.
// Optional trailing even-parity bit: define PISO_SERIALIZER_PARITY_EN.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH = PISO_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    piso_state_e      r_state;
    piso_state_e      w_state_nxt;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_cnt;
    logic             w_load;
    logic             w_adv;
`ifdef PISO_SERIALIZER_PARITY_EN
    logic             r_par;
`endif

    // Next-state decode and outputs; outputs follow state so an async reset clears them at once.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_adv       = 1'b0;
        load_ready  = 1'b0;
        busy        = 1'b1;
        ser_out     = 1'b0;
        ser_valid   = 1'b0;
        ser_last    = 1'b0;
        case (r_state)
            IDLE: begin
                load_ready = 1'b1;
                busy       = 1'b0;
                if (load_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = SHIFT;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SHIFT: begin
                ser_out   = r_shreg[0];
                ser_valid = shift_en;
                w_adv     = shift_en;
                if (r_cnt == LAST_IDX) begin
`ifdef PISO_SERIALIZER_PARITY_EN
                    ser_last    = 1'b0;
                    w_state_nxt = shift_en ? PARITY : SHIFT;
`else
                    ser_last    = 1'b1;
                    w_state_nxt = shift_en ? IDLE : SHIFT;
`endif
                end else begin
                    ser_last    = 1'b0;
                    w_state_nxt = SHIFT;
                end
            end
`ifdef PISO_SERIALIZER_PARITY_EN
            PARITY: begin
                ser_out   = r_par;
                ser_valid = shift_en;
                ser_last  = 1'b1;
                if (shift_en) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = PARITY;
                end
            end
`endif
            default: begin
                busy        = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, shift register and bit counter; the counter saturates at the last data bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_shreg <= {WIDTH{1'b0}};
            r_cnt   <= {CW{1'b0}};
`ifdef PISO_SERIALIZER_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_shreg <= data_in;
                r_cnt   <= {CW{1'b0}};
`ifdef PISO_SERIALIZER_PARITY_EN
                r_par   <= ^data_in;
`endif
            end else if (w_adv) begin
                r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
                if (r_cnt != LAST_IDX) begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: a frame-level model queues the expected
// serial bits on acceptance; a negedge monitor compares every visible output.
module tb_piso_serializer;
    import piso_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         load_valid = 1'b0;
    logic         load_ready;
    logic         shift_en = 1'b0;
    logic         ser_out;
    logic         ser_valid;
    logic         ser_last;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int frames = 0;
    bit exp_q[$];

    piso_serializer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .shift_en   (shift_en),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .ser_last   (ser_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0b expected=%0b at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: an empty queue means idle; acceptance queues the whole frame.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_q.delete();
        end else if (exp_q.size() == 0) begin
            if (load_valid) begin
                for (int i = 0; i < W; i++) exp_q.push_back(data_in[i]);
`ifdef PISO_SERIALIZER_PARITY_EN
                exp_q.push_back(^data_in);
`endif
                frames++;
            end
        end else if (shift_en) begin
            void'(exp_q.pop_front());
        end
    end

    // Monitor: compare the DUT outputs against the head of the expected stream.
    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_load_ready", load_ready, 1'b1);
            chk("rst_busy",       busy,       1'b0);
            chk("rst_ser_valid",  ser_valid,  1'b0);
            chk("rst_ser_out",    ser_out,    1'b0);
            chk("rst_ser_last",   ser_last,   1'b0);
        end else if (exp_q.size() == 0) begin
            chk("idle_load_ready", load_ready, 1'b1);
            chk("idle_busy",       busy,       1'b0);
            chk("idle_ser_valid",  ser_valid,  1'b0);
            chk("idle_ser_out",    ser_out,    1'b0);
            chk("idle_ser_last",   ser_last,   1'b0);
        end else begin
            chk("frm_load_ready", load_ready, 1'b0);
            chk("frm_busy",       busy,       1'b1);
            chk("frm_ser_valid",  ser_valid,  shift_en);
            chk("frm_ser_out",    ser_out,    exp_q[0]);
            chk("frm_ser_last",   ser_last,   exp_q.size() == 1);
        end
    end

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input logic [W-1:0] d);
        data_in    = d;
        load_valid = 1'b1;
        cyc(1);
        load_valid = 1'b0;
    endtask

    initial begin
        cyc(3);
        rst = 1'b1;

        // A5 streamed without stalls, then a gap.
        shift_en = 1'b1;
        load(8'hA5);
        cyc(W + 4);

        // 3C with a three-cycle stall after bit 2 becomes visible.
        load(8'h3C);
        cyc(2);
        shift_en = 1'b0;
        cyc(3);
        shift_en = 1'b1;
        cyc(W + 3);

        // 00 frame while FF is offered continuously; FF accepted only after the gap.
        load(8'h00);
        data_in    = 8'hFF;
        load_valid = 1'b1;
        cyc(3 * W);
        load_valid = 1'b0;
        cyc(W + 3);

        // 07 frame (odd parity word).
        load(8'h07);
        cyc(W + 3);

        // Reset asserted mid-frame aborts the word.
        load(8'h5A);
        cyc(3);
        rst = 1'b0;
        #1;
        chk("async_rst_busy",      busy,      1'b0);
        chk("async_rst_ser_valid", ser_valid, 1'b0);
        chk("async_rst_ready",     load_ready, 1'b1);
        cyc(2);
        rst = 1'b1;
        load(8'hC3);
        cyc(W + 3);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            data_in    = W'($urandom);
            load_valid = ($urandom_range(0, 2) != 0);
            shift_en   = ($urandom_range(0, 9) < 7);
            cyc(1);
        end

        // Drain with a bounded number of cycles.
        load_valid = 1'b0;
        shift_en   = 1'b1;
        cyc(2 * W + 4);
        chk("final_busy", busy, 1'b0);
        chk("frames_seen", frames > 6, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
